// File: rtl/xbar_pkg.sv
// ============================================================================
// Module      : xbar_pkg
// Description : Shared definitions for the N x N registered crossbar.
//               Holds the default geometry, the configuration FSM state
//               type and a helper that builds the identity source table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package xbar_pkg;

  localparam int XBAR_N_DEFAULT = 4;
  localparam int XBAR_W_DEFAULT = 4;

  // Upper bound on the packed table width returned by identity_cfg. Callers
  // take the low N*$clog2(N) bits.
  localparam int XBAR_CFG_MAXW = 1024;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } xbar_state_t;

  // Packed table where field i (width $clog2(n)) holds the value i.
  function automatic logic [XBAR_CFG_MAXW-1:0] identity_cfg(input int n);
    logic [XBAR_CFG_MAXW-1:0] tbl;
    int                       selw;
    tbl  = '0;
    selw = $clog2(n);
    for (int i = 0; i < n; i++) begin
      tbl = tbl | (XBAR_CFG_MAXW'(i) << (i * selw));
    end
    return tbl;
  endfunction

endpackage

`default_nettype wire

// File: rtl/xbar_cfg_check.sv
// ============================================================================
// Module      : xbar_cfg_check
// Description : Combinational legality check of a pending source table.
//               A table is legal when every field is below N and, unless
//               XBAR_BROADCAST_EN is defined, no two outputs name the same
//               source.
// Ports       : i_pend  - packed table, field i at [i*SELW +: SELW]
//               o_legal - high when the table may become active
// Macro       : XBAR_BROADCAST_EN - allow duplicate sources (multicast)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xbar_cfg_check #(
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N*SELW-1:0] i_pend,
  output logic              o_legal
);

  logic w_range_ok;
  logic w_dup_ok;

  // Only reachable when N is not a power of two.
  always_comb begin
    w_range_ok = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (int'(i_pend[i*SELW +: SELW]) >= N) begin
        w_range_ok = 1'b0;
      end
    end
  end

`ifdef XBAR_BROADCAST_EN
  assign w_dup_ok = 1'b1;
`else
  // Pairwise compare of every output's source against every later one.
  always_comb begin
    w_dup_ok = 1'b1;
    for (int i = 0; i < N; i++) begin
      for (int j = i + 1; j < N; j++) begin
        if (i_pend[i*SELW +: SELW] == i_pend[j*SELW +: SELW]) begin
          w_dup_ok = 1'b0;
        end
      end
    end
  end
`endif

  assign o_legal = w_range_ok & w_dup_ok;

endmodule

`default_nettype wire

// File: rtl/xbar_nxn_reg.sv
// ============================================================================
// Module      : xbar_nxn_reg
// Description : Parametrised N-port, W-bit registered crossbar. Each output
//               selects any input through the active source table. A new
//               table arrives over a valid/ready handshake, is checked for
//               one cycle and then either replaces the active table or is
//               rejected with a one-cycle cfg_err pulse.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               in_data      - input port i at [i*W +: W]
//               in_valid     - per-input valid
//               cfg_sel      - source of output i at [i*SELW +: SELW]
//               cfg_valid    - config offered
//               cfg_ready    - config can be accepted (IDLE)
//               out_data     - registered outputs, one cycle latency
//               out_valid    - registered per-output valid
//               cfg_err      - one-cycle pulse on a rejected config
//               cfg_busy     - high during the CHECK cycle
// Macro       : XBAR_BROADCAST_EN - duplicate sources are legal (multicast)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xbar_nxn_reg
  import xbar_pkg::*;
#(
  parameter  int N    = XBAR_N_DEFAULT,
  parameter  int W    = XBAR_W_DEFAULT,
  localparam int SELW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*W-1:0]    in_data,
  input  logic [N-1:0]      in_valid,
  input  logic [N*SELW-1:0] cfg_sel,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic [N*W-1:0]    out_data,
  output logic [N-1:0]      out_valid,
  output logic              cfg_err,
  output logic              cfg_busy
);

  localparam logic [XBAR_CFG_MAXW-1:0] c_ident_full = identity_cfg(N);
  localparam logic [N*SELW-1:0]        c_ident      = c_ident_full[N*SELW-1:0];

  xbar_state_t       r_state;
  logic [N*SELW-1:0] r_pend;
  logic [N*SELW-1:0] r_act;
  logic [N*W-1:0]    r_out_data;
  logic [N-1:0]      r_out_valid;
  logic              r_cfg_err;
  logic              r_cfg_busy;
  logic              r_cfg_ready;

  logic              w_legal;
  logic [N*W-1:0]    w_mux_data;
  logic [N-1:0]      w_mux_valid;

  // Per-output source mux driven by the active table. The active table is
  // only ever loaded from a legal pending table, so every select is in range.
  for (genvar gi = 0; gi < N; gi++) begin : g_out
    logic [SELW-1:0] w_sel;
    assign w_sel                   = r_act[gi*SELW +: SELW];
    assign w_mux_data[gi*W +: W]   = in_data[w_sel*W +: W];
    assign w_mux_valid[gi]         = in_valid[w_sel];
  end

  xbar_cfg_check #(
    .N (N)
  ) u_cfg_check (
    .i_pend  (r_pend),
    .o_legal (w_legal)
  );

  // The active table changes on the edge that ends CHECK; the data captured
  // on that same edge still used the old table, so no output ever sees a
  // mixture of tables.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pend      <= '0;
      r_act       <= c_ident;
      r_out_data  <= '0;
      r_out_valid <= '0;
      r_cfg_err   <= 1'b0;
      r_cfg_busy  <= 1'b0;
      r_cfg_ready <= 1'b1;
    end else begin
      r_out_data  <= w_mux_data;
      r_out_valid <= w_mux_valid;
      r_cfg_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cfg_valid && r_cfg_ready) begin
            r_pend      <= cfg_sel;
            r_state     <= CHECK;
            r_cfg_ready <= 1'b0;
            r_cfg_busy  <= 1'b1;
          end
        end
        CHECK: begin
          if (w_legal) begin
            r_act <= r_pend;
          end else begin
            r_cfg_err <= 1'b1;
          end
          r_state     <= IDLE;
          r_cfg_ready <= 1'b1;
          r_cfg_busy  <= 1'b0;
        end
        default: begin
          r_state     <= IDLE;
          r_cfg_ready <= 1'b1;
          r_cfg_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign cfg_err   = r_cfg_err;
  assign cfg_busy  = r_cfg_busy;
  assign cfg_ready = r_cfg_ready;

endmodule

`default_nettype wire
